// File: rtl/mandel_pkg.sv
// Shared types and defaults for the Mandelbrot pixel pipeline.
package mandel_pkg;

  localparam int X_SIZE_DEFAULT = 640;
  localparam int Y_SIZE_DEFAULT = 480;
  localparam int X_W            = 10;
  localparam int Y_W            = 9;

  typedef logic [X_W-1:0] coord_x_t;
  typedef logic [Y_W-1:0] coord_y_t;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgb_t;

endpackage

// File: rtl/pixel_stream_buffer_if.sv
// Pixel handshake bundle: colour-LUT side in, packer side out.
interface pixel_stream_buffer_if
  import mandel_pkg::*;
();

  rgb_t       in_color;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_r;
  logic [7:0] out_g;
  logic [7:0] out_b;
  logic       out_valid;
  logic       out_ready;
  logic       out_sof;
  logic       out_eol;

  // Environment side: drives pixels in, accepts pixels out.
  modport master (
    output in_color, in_valid, out_ready,
    input  in_ready, out_r, out_g, out_b, out_valid, out_sof, out_eol
  );

  // Buffer side.
  modport slave (
    input  in_color, in_valid, out_ready,
    output in_ready, out_r, out_g, out_b, out_valid, out_sof, out_eol
  );

endinterface

// File: rtl/raster_counter.sv
// Raster x/y position and frame counter, advanced one pixel per strobe.
module raster_counter
  import mandel_pkg::*;
#(
  parameter int X_SIZE = X_SIZE_DEFAULT,
  parameter int Y_SIZE = Y_SIZE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       advance,
  output coord_x_t   x,
  output coord_y_t   y,
  output logic [7:0] frame_count,
  output logic       sof,
  output logic       eol
);

  localparam coord_x_t X_LAST = coord_x_t'(X_SIZE - 1);
  localparam coord_y_t Y_LAST = coord_y_t'(Y_SIZE - 1);

  // frame_count survives clear so debug readback spans frame restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      frame_count <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= '0;
        if (y == Y_LAST) begin
          y           <= '0;
          frame_count <= frame_count + 8'd1;
        end else begin
          y <= y + coord_y_t'(1);
        end
      end else begin
        x <= x + coord_x_t'(1);
      end
    end
  end

  assign sof = (x == '0) && (y == '0);
  assign eol = (x == X_LAST);

endmodule

// File: rtl/pixel_stream_buffer.sv
// First-word-fall-through elastic buffer between colour LUT and stream packer,
// tagging output pixels with raster flags from output-side counters.
module pixel_stream_buffer
  import mandel_pkg::*;
#(
  parameter  int X_SIZE = X_SIZE_DEFAULT,
  parameter  int Y_SIZE = Y_SIZE_DEFAULT,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                  out_stream_aclk,
  input  logic                  periph_resetn,
  input  logic                  sync_clear,
  pixel_stream_buffer_if.slave  bus,
  output coord_x_t              x_out,
  output coord_y_t              y_out,
  output logic [AW:0]           level,
  output logic [7:0]            frame_count,
  output logic                  overflow
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  rgb_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          ready_en;
  logic          full;
  logic          push;
  logic          pop;
  rgb_t          head;

  assign full          = (level == FULL_LEVEL);
  assign bus.in_ready  = ready_en & ~full;
  assign bus.out_valid = (level != '0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // ready_en holds in_ready low through reset and releases it at the first edge.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (sync_clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        unique case ({push, pop})
          2'b10:   level <= level + (AW+1)'(1);
          2'b01:   level <= level - (AW+1)'(1);
          default: level <= level;
        endcase
        if (bus.in_valid && full) overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge out_stream_aclk) begin
    if (push && !sync_clear) mem[wr_ptr] <= bus.in_color;
  end

  assign head      = mem[rd_ptr];
  assign bus.out_r = head.r;
  assign bus.out_g = head.g;
  assign bus.out_b = head.b;

  raster_counter #(
    .X_SIZE (X_SIZE),
    .Y_SIZE (Y_SIZE)
  ) u_raster (
    .clk         (out_stream_aclk),
    .rst_n       (periph_resetn),
    .clear       (sync_clear),
    .advance     (pop),
    .x           (x_out),
    .y           (y_out),
    .frame_count (frame_count),
    .sof         (bus.out_sof),
    .eol         (bus.out_eol)
  );

endmodule

// File: tb/tb_pixel_stream_buffer.sv
// Scoreboard bench for pixel_stream_buffer with a small 4x2 raster.
module tb_pixel_stream_buffer;
  import mandel_pkg::*;

  localparam int TX    = 4;
  localparam int TY    = 2;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  typedef struct {
    logic [23:0] c;
    logic        sof;
    logic        eol;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        sync_clear;
  coord_x_t    x_out;
  coord_y_t    y_out;
  logic [AW:0] level;
  logic [7:0]  frame_count;
  logic        overflow;

  pixel_stream_buffer_if bus();

  pixel_stream_buffer #(
    .X_SIZE (TX),
    .Y_SIZE (TY),
    .DEPTH  (DEPTH)
  ) dut (
    .out_stream_aclk (clk),
    .periph_resetn   (rst_n),
    .sync_clear      (sync_clear),
    .bus             (bus),
    .x_out           (x_out),
    .y_out           (y_out),
    .level           (level),
    .frame_count     (frame_count),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   k;
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock of stimulus; accepted pixels enter the scoreboard with their raster flags.
  task automatic cycle(input logic v, input logic [23:0] c, input logic rdy, input logic clr);
    logic acc;
    bus.in_valid  = v;
    bus.in_color  = c;
    bus.out_ready = rdy;
    sync_clear    = clr;
    @(negedge clk);
    acc = v && bus.in_ready && !clr;
    @(posedge clk);
    if (clr) begin
      sb.delete();
      k = 0;
    end else if (acc) begin
      sb.push_back('{c, (k % (TX*TY)) == 0, (k % TX) == TX-1});
      k++;
    end
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    sync_clear    = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_pop: got %0h expected none",
                   {bus.out_b, bus.out_g, bus.out_r});
        end else begin
          e = sb.pop_front();
          check("pop_color", 32'({bus.out_b, bus.out_g, bus.out_r}), 32'(e.c));
          check("pop_sof", 32'(bus.out_sof), 32'(e.sof));
          check("pop_eol", 32'(bus.out_eol), 32'(e.eol));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    k             = 0;
    rst_n         = 1'b0;
    sync_clear    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_color  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("rst_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("release_in_ready_pre_edge", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    check("release_in_ready", 32'(bus.in_ready), 1);
    check("release_level", 32'(level), 0);
    check("release_out_valid", 32'(bus.out_valid), 0);

    // single push, FWFT visibility
    cycle(1'b1, 24'h3366CC, 1'b0, 1'b0);
    check("single_valid", 32'(bus.out_valid), 1);
    check("single_r", 32'(bus.out_r), 32'h CC);
    check("single_g", 32'(bus.out_g), 32'h66);
    check("single_b", 32'(bus.out_b), 32'h33);
    check("single_sof", 32'(bus.out_sof), 1);
    check("single_level", 32'(level), 1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("single_x_after_pop", 32'(x_out), 1);
    check("single_level_after_pop", 32'(level), 0);

    // fill past full
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 24'h100000 + 24'(i), 1'b0, 1'b0);
      if (i == 15) begin
        check("fill16_in_ready", 32'(bus.in_ready), 0);
        check("fill16_overflow", 32'(overflow), 0);
      end
    end
    check("fill_level", 32'(level), 16);
    check("fill_overflow", 32'(overflow), 1);
    check("fill_in_ready", 32'(bus.in_ready), 0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("fill_pop_level", 32'(level), 15);
    check("fill_pop_in_ready", 32'(bus.in_ready), 1);

    // concurrent push/pop at level 8
    repeat (7) cycle(1'b0, '0, 1'b1, 1'b0);
    check("conc_start_level", 32'(level), 8);
    for (int i = 0; i < 100; i++) cycle(1'b1, 24'h200000 + 24'(i), 1'b1, 1'b0);
    check("conc_level", 32'(level), 8);
    for (int n = 0; n < 64 && level != 0; n++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("drain_level", 32'(level), 0);
    // 117 pops on a 4x2 raster: 14 frames, then position 5
    check("drain_frame", 32'(frame_count), 14);
    check("drain_x", 32'(x_out), 1);
    check("drain_y", 32'(y_out), 1);
    check("overflow_sticky", 32'(overflow), 1);

    // raster wrap from a clean position
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("clr_overflow", 32'(overflow), 0);
    check("clr_x", 32'(x_out), 0);
    check("clr_y", 32'(y_out), 0);
    check("clr_frame_kept", 32'(frame_count), 14);
    for (int i = 0; i < 9; i++) cycle(1'b1, 24'h300000 + 24'(i), 1'b0, 1'b0);
    repeat (7) cycle(1'b0, '0, 1'b1, 1'b0);
    check("wrap_frame_pre", 32'(frame_count), 14);
    check("wrap_eol_head8", 32'(bus.out_eol), 1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("wrap_frame_post", 32'(frame_count), 15);
    check("wrap_sof_head9", 32'(bus.out_sof), 1);
    check("wrap_eol_head9", 32'(bus.out_eol), 0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // sync_clear with a concurrent push
    for (int i = 0; i < 8; i++) cycle(1'b1, 24'h400000 + 24'(i), 1'b0, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);
    check("pre_clr_x", 32'(x_out), 3);
    check("pre_clr_level", 32'(level), 6);
    cycle(1'b1, 24'hDEAD01, 1'b0, 1'b1);
    check("sc_level", 32'(level), 0);
    check("sc_x", 32'(x_out), 0);
    check("sc_out_valid", 32'(bus.out_valid), 0);
    check("sc_frame", 32'(frame_count), 15);
    cycle(1'b1, 24'hAABBCC, 1'b0, 1'b0);
    check("sc_next_level", 32'(level), 1);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // async reset mid-stream at level 5
    for (int i = 0; i < 5; i++) cycle(1'b1, 24'h500000 + 24'(i), 1'b0, 1'b0);
    check("mid_level", 32'(level), 5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 0);
    check("arst_level", 32'(level), 0);
    check("arst_x", 32'(x_out), 0);
    check("arst_y", 32'(y_out), 0);
    check("arst_frame", 32'(frame_count), 0);
    check("arst_overflow", 32'(overflow), 0);
    check("arst_in_ready", 32'(bus.in_ready), 0);
    sb.delete();
    k = 0;
    @(negedge clk) rst_n = 1'b1;
    #1 check("arst_release_pre_edge", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1 check("arst_release_in_ready", 32'(bus.in_ready), 1);
    cycle(1'b1, 24'h0102FE, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pixel_stream_buffer.md
Name: pixel_stream_buffer

Overview:
Elastic buffer between the colour lookup stage and the AXI-Stream packer in the Mandelbrot pixel pipeline. It absorbs the variable per-pixel latency of the escape-time engine. It presents pixels in raster order with start-of-frame and end-of-line flags generated from its own output-side coordinate counters. It also reports fill level and frame count for debug readback.

Parameters:
X_SIZE, 640, pixels per line
Y_SIZE, 480, lines per frame
DEPTH, 16, FIFO entries; power of two, >= 2
AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
out_stream_aclk  in  1  sole clock
periph_resetn  in  1  asynchronous active-low reset
sync_clear  in  1  synchronous flush of FIFO and counters (frame restart)
in_color  in  24  {b[23:16], g[15:8], r[7:0]} from colour LUT
in_valid  in  1  in_color valid
in_ready  out  1  buffer can accept
out_r  out  8  red to packer
out_g  out  8  green to packer
out_b  out  8  blue to packer
out_valid  out  1  pixel available
out_ready  in  1  packer ready (in_stream_ready)
out_sof  out  1  head pixel is x=0,y=0
out_eol  out  1  head pixel is x=X_SIZE-1
x_out  out  10  output-side x counter
y_out  out  9  output-side y counter
level  out  AW+1  current occupancy, 0..DEPTH
frame_count  out  8  completed frames, wraps
overflow  out  1  sticky: in_valid seen while full

Behaviour:
- Reset (periph_resetn=0, async): pointers, level, x, y, frame_count, overflow = 0. out_valid=0. in_ready=0 while reset is asserted; in_ready=1 from the first clock edge after release. Reset mid-frame discards all contents.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (level != DEPTH), registered-equivalent. It has no combinational dependence on out_ready, so there is no same-cycle pass-through when full.
- out_valid = (level != 0). Head data is read combinationally from the storage entry at rd_ptr (first-word-fall-through).
- Latency: a pixel pushed at edge N is visible on out_* after edge N and poppable in cycle N+1. Minimum latency is 1 cycle, with no bypass.
- Push and pop in the same cycle: level is unchanged and both pointers advance. This is legal at any level except full, where no push is possible.
- Pointers are AW bits and wrap modulo DEPTH. level is tracked as a separate AW+1 counter.
- x/y advance only on pop:
  - x==X_SIZE-1 → x=0, then y increments; if y==Y_SIZE-1, y=0 and frame_count increments (255 wraps to 0).
  - Otherwise x increments.
- out_sof = (x==0 & y==0); out_eol = (x==X_SIZE-1). Both are combinational from the counters and meaningful only when out_valid=1.
- overflow sets when in_valid=1 and level==DEPTH. It clears only on reset or sync_clear.
- sync_clear=1 at an edge:
  - pointers, level, x, y, overflow = 0; frame_count is kept.
  - A push or pop in the same cycle is discarded.
  - out_valid=0 on the following cycle.
- Colour mapping: out_r=head[7:0], out_g=head[15:8], out_b=head[23:16].
- Storage has no reset; only the control registers are reset.

Decomposition:
- Shared package mandel_pkg: typedef rgb_t (24-bit b,g,r), constants X_SIZE/Y_SIZE defaults, coordinate widths (10/9).
- One natural sub-module: raster_counter (x/y/frame_count with advance, sync_clear, sof/eol outputs). It is reusable by the upstream coordinate generator.
- FIFO storage and control stay inline.

Test Plan:
- Reset: assert periph_resetn=0 mid-stream with level=5 → out_valid=0, level=0, x_out=0, y_out=0, overflow=0 immediately (async), in_ready=1 one edge after release.
- Single push: in_color=24'h3366CC at edge N, out_ready=0 → cycle N+1: out_valid=1, out_r=CC, out_g=66, out_b=33, out_sof=1, level=1.
- Fill: out_ready=0, push 17 pixels with DEPTH=16 → in_ready=0 after the 16th, level=16, overflow=1; pop once → in_ready=1 next cycle, level=15.
- Concurrent: level=8, in_valid=out_ready=1 for 100 cycles → level stays 8 and output order equals input order.
- Raster wrap (X_SIZE=4, Y_SIZE=2): pop 8 pixels → out_eol on pops 4 and 8, out_sof on pops 1 and 9, frame_count 0→1 after pop 8.
- sync_clear: level=6, x=3, frame_count=2, pulse sync_clear with in_valid=1 → next cycle level=0, x=0, out_valid=0, frame_count=2, pushed pixel dropped.
